// File: rtl/gpu_pkg.sv
// Shared GPU definitions for the pixel store and its consumers.
//   pixel_t        : one stored pixel word
//   INVALID_PIXEL  : value marking an empty / not-drawn pixel
//   reader_state_t : frame-sweep states of ram_pixel_reader
package gpu_pkg;

  localparam int PIX_W = 12;

  typedef logic [PIX_W-1:0] pixel_t;

  localparam pixel_t INVALID_PIXEL = '0;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } reader_state_t;

endpackage

// File: rtl/ram_pixel_reader_if.sv
// Bundle between ram_pixel_reader, the RAM read port and the pixel stream.
//   master : the reader (drives rd_add, pixel stream, status)
//   slave  : the environment (drives start, rd_data, pix_ready)
// Signals:
//   start     frame-sweep request pulse
//   rd_add    RAM read address        rd_data   RAM registered read data
//   pix_data  pixel value             pix_addr  RAM address of the pixel
//   pix_valid stream valid            pix_ready stream ready
//   busy      sweep in progress       done      one-cycle end-of-frame pulse
//   skip_cnt  pixels dropped in the current / last frame
interface ram_pixel_reader_if #(
  parameter int ram_width  = 8,
  parameter int data_width = 12
) ();

  logic                  start;
  logic [ram_width-1:0]  rd_add;
  logic [data_width-1:0] rd_data;
  logic [data_width-1:0] pix_data;
  logic [ram_width-1:0]  pix_addr;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  busy;
  logic                  done;
  logic [ram_width:0]    skip_cnt;

  modport master (
    input  start, rd_data, pix_ready,
    output rd_add, pix_data, pix_addr, pix_valid, busy, done, skip_cnt
  );

  modport slave (
    output start, rd_data, pix_ready,
    input  rd_add, pix_data, pix_addr, pix_valid, busy, done, skip_cnt
  );

endinterface

// File: rtl/pix_fifo2.sv
// Two-entry register FIFO carrying a {data, addr} pixel payload.
// Entry 0 is always the head, so the head outputs come straight from flops
// and only change on a pop (or on the push into an empty FIFO).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_push, i_data/i_addr write one payload
//   i_pop                 remove the head (only when o_valid)
//   o_data, o_addr        head payload
//   o_valid               FIFO not empty
//   o_cnt                 fill level 0..2
module pix_fifo2 #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_valid,
  output logic [1:0]        o_cnt
);

  logic [DATA_W-1:0] r_data0, r_data1;
  logic [ADDR_W-1:0] r_addr0, r_addr1;
  logic [1:0]        r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data0 <= '0;
      r_addr0 <= '0;
      r_data1 <= '0;
      r_addr1 <= '0;
      r_cnt   <= 2'd0;
    end else begin
      unique case (r_cnt)
        2'd0: begin
          if (i_push) begin
            r_data0 <= i_data;
            r_addr0 <= i_addr;
            r_cnt   <= 2'd1;
          end
        end
        2'd1: begin
          if (i_push && i_pop) begin
            r_data0 <= i_data;
            r_addr0 <= i_addr;
          end else if (i_push) begin
            r_data1 <= i_data;
            r_addr1 <= i_addr;
            r_cnt   <= 2'd2;
          end else if (i_pop) begin
            r_cnt   <= 2'd0;
          end
        end
        2'd2: begin
          // Full: a pop shifts entry 1 to the head; a simultaneous push
          // refills entry 1 and the level stays at 2.
          if (i_pop) begin
            r_data0 <= r_data1;
            r_addr0 <= r_addr1;
            if (i_push) begin
              r_data1 <= i_data;
              r_addr1 <= i_addr;
            end else begin
              r_cnt   <= 2'd1;
            end
          end
        end
        default: r_cnt <= 2'd0;
      endcase
    end
  end

  assign o_data  = r_data0;
  assign o_addr  = r_addr0;
  assign o_valid = (r_cnt != 2'd0);
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/ram_pixel_reader.sv
// Sweeps the RAM read port over a whole frame (address 0 .. 2**ram_width-1),
// absorbs the RAM's one-cycle read latency, optionally drops pixels equal to
// INVALID_PIXEL and hands the rest out on a valid/ready stream.
// Ports:
//   rd_clk  single clock, shared with the RAM read port
//   rst_n   asynchronous active-low reset
//   bus     ram_pixel_reader_if.master (start, RAM read port, pixel stream,
//           busy/done/skip_cnt status)
module ram_pixel_reader
  import gpu_pkg::*;
#(
  parameter int ram_width    = 8,
  parameter int data_width   = 12,
  parameter bit skip_invalid = 1'b1
) (
  input  logic                rd_clk,
  input  logic                rst_n,
  ram_pixel_reader_if.master  bus
);

  localparam logic [ram_width-1:0] LAST_ADD = '1;

  reader_state_t         r_state, w_next;
  logic [ram_width-1:0]  r_rd_add;
  logic [ram_width-1:0]  r_shadow_add;
  logic                  r_rd_pend;
  logic                  r_busy;
  logic [ram_width:0]    r_skip_cnt;

  logic                  w_issue;
  logic                  w_start_ok;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_discard;
  logic                  w_fifo_valid;
  logic [1:0]            w_fifo_cnt;
  logic [data_width-1:0] w_head_data;
  logic [ram_width-1:0]  w_head_addr;

  assign w_pop     = w_fifo_valid & bus.pix_ready;
  // rd_data belongs to the address issued last cycle only when rd_pend is set
  assign w_discard = r_rd_pend & skip_invalid &
                     (bus.rd_data == data_width'(INVALID_PIXEL));
  assign w_push    = r_rd_pend & ~w_discard;

  always_comb begin
    w_next     = r_state;
    w_issue    = 1'b0;
    w_start_ok = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_start_ok = 1'b1;
          w_next     = READ;
        end
      end
      READ: begin
        // Occupancy after this cycle's pop plus the word still in flight must
        // leave room for the word about to be requested.
        if (({1'b0, w_fifo_cnt} + {2'b00, r_rd_pend}) < (3'd2 + {2'b00, w_pop})) begin
          w_issue = 1'b1;
          if (r_rd_add == LAST_ADD) begin
            w_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!r_rd_pend && (w_fifo_cnt == 2'd0)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rd_add     <= '0;
      r_shadow_add <= '0;
      r_rd_pend    <= 1'b0;
      r_busy       <= 1'b0;
      r_skip_cnt   <= '0;
    end else begin
      r_state   <= w_next;
      r_rd_pend <= w_issue;
      if (w_start_ok) begin
        r_rd_add   <= '0;
        r_busy     <= 1'b1;
        r_skip_cnt <= '0;
      end
      if (w_issue) begin
        r_shadow_add <= r_rd_add;
        // The address parks at the top after the last read; no wrap.
        if (r_rd_add != LAST_ADD) begin
          r_rd_add <= r_rd_add + 1'b1;
        end
      end
      if (w_discard) begin
        r_skip_cnt <= r_skip_cnt + 1'b1;
      end
      if (r_state == DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

  pix_fifo2 #(
    .DATA_W (data_width),
    .ADDR_W (ram_width)
  ) u_fifo (
    .clk     (rd_clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (bus.rd_data),
    .i_addr  (r_shadow_add),
    .i_pop   (w_pop),
    .o_data  (w_head_data),
    .o_addr  (w_head_addr),
    .o_valid (w_fifo_valid),
    .o_cnt   (w_fifo_cnt)
  );

  assign bus.rd_add    = r_rd_add;
  assign bus.pix_data  = w_head_data;
  assign bus.pix_addr  = w_head_addr;
  assign bus.pix_valid = w_fifo_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = (r_state == DONE);
  assign bus.skip_cnt  = r_skip_cnt;

endmodule
